alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Integer execution unit of the out-of-order core; the consumer of the 4-bit ALU control code produced by the decode-stage ALU controller.
- Accepts one issued op per cycle from the ALU reservation station via valid/ready. Computes the result and buffers it in a 2-entry result FIFO.
- Broadcasts results on the common data bus (CDB) under a valid/grant handshake with the CDB arbiter; supports pipeline flush.

Parameters:
- XLEN, 32, operand/result width; shift amount uses the low $clog2(XLEN) bits of src2.
- TAG_W, 5, ROB tag width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all in-flight ops.
- issue_valid  in  1  reservation station presents an op.
- issue_ready  out  1  unit can accept an op this cycle.
- issue_ctrl  in  4  ALU control code.
- issue_src1  in  XLEN  operand A.
- issue_src2  in  XLEN  operand B: register value or immediate.
- issue_tag  in  TAG_W  ROB tag of the op.
- cdb_valid  out  1  result at FIFO head is offered to the CDB.
- cdb_tag  out  TAG_W  tag of the head result.
- cdb_result  out  XLEN  head result value.
- cdb_grant  in  1  arbiter accepts the head this cycle.
- busy  out  1  FIFO non-empty.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low asynchronously clears the FIFO: count=0, rd_ptr=0, wr_ptr=0.
  - Reset values: cdb_valid=0, busy=0, issue_ready=1, cdb_tag=0, cdb_result=0.
- Opcode map (issue_ctrl -> result):
  - 0010 ADD: src1+src2, modulo 2^XLEN.
  - 0110 SUB: src1-src2, modulo 2^XLEN.
  - 0011 XOR: src1^src2.
  - 0001 OR: src1|src2.
  - 0111 SRA: $signed(src1) >>> src2[$clog2(XLEN)-1:0].
  - 1111 PASS: src2 (LUI path; immediate already formed upstream).
  - Any other code is illegal: result 0.
- Issue side:
  - Accept occurs when issue_valid && issue_ready.
  - On accept, the result is computed combinationally and the result plus tag are written at wr_ptr in the same edge.
  - issue_ready = (count < 2). It is registered-count based, with no combinational dependence on cdb_grant.
- CDB side:
  - cdb_valid = (count != 0).
  - cdb_tag and cdb_result always show the entry at rd_ptr; they are 0 when empty (head entry zeroed on pop).
  - Pop occurs when cdb_valid && cdb_grant. Grant while cdb_valid=0 is ignored.
  - While cdb_valid=1 and no grant, head outputs hold stable.
- Latency: accept at edge N with an empty FIFO -> cdb_valid=1 in the cycle after edge N. Throughput is 1 op/cycle while the arbiter grants every cycle.
- Simultaneous accept and pop: count unchanged, both pointers advance; order is strictly FIFO.
- Full (count=2): issue_ready=0 even if cdb_grant=1 that cycle. Ready returns the cycle after the pop.
- Pointers are 1 bit and wrap 1->0.
- Flush:
  - flush=1 at an edge sets count=0 and pointers=0.
  - The same-cycle issue is dropped, and a same-cycle grant is discarded (flush wins).
  - Next cycle: cdb_valid=0, issue_ready=1.
- Reset mid-operation: all buffered results are lost immediately; nothing is broadcast after rst_n deasserts until a new accept.

Optional Feature:
- Macro ALU_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port cdb_illegal (1 bit), stored per FIFO entry.
  - Set for an illegal issue_ctrl; it accompanies cdb_valid and resets to 0.
  - The ROB raises an illegal-instruction exception from it.
- Undefined: port absent; illegal codes silently produce result 0 with no indication.

Test Plan:
- Reset, then issue ADD src1=0x0000_0005, src2=0x0000_0003, tag=7, with grant held high -> next cycle cdb_valid=1, tag=7, result=0x0000_0008; cdb_valid low the following cycle.
- SUB 0x0000_0000-0x0000_0001 -> 0xFFFF_FFFF.
  - SRA 0x8000_0000 by src2=0x0000_0024 (shamt 4) -> 0xF800_0000.
  - PASS src2=0x1234_5000 -> 0x1234_5000.
  - XOR 0xFF00_FF00^0x0F0F_0F0F -> 0xF00F_F00F.
- Grant held low, issue tags 1, 2, 3 back-to-back -> tags 1 and 2 accepted, issue_ready=0 on the third, head holds tag 1. Then grant one cycle -> tag 1 popped, ready=1 next cycle; tag 3 accepted, and tags 2 and 3 are then broadcast in order.
- Full FIFO, assert flush together with issue_valid and cdb_grant -> next cycle cdb_valid=0, busy=0, issue_ready=1; the dropped op never appears on the CDB.
- Drop rst_n asynchronously mid-cycle with 2 entries buffered -> cdb_valid=0 immediately, before the next edge. After release, a fresh ADD tag=4 appears with 1-cycle latency.
- issue_ctrl=0101, src1=0xA, src2=0xB -> result 0; with ALU_ILLEGAL_TRAP_EN, cdb_illegal=1 for that entry only, and a following OR op reports cdb_illegal=0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - integer execution unit with 2-entry result FIFO and CDB handshake
//
// Optional feature macro: ALU_ILLEGAL_TRAP_EN (adds cdb_illegal, stored per entry)
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   flush                      synchronous squash of every buffered and issuing op
//   issue_valid/issue_ready    reservation-station handshake
//   issue_ctrl/src1/src2/tag   ALU control code, operands, ROB tag
//   cdb_valid/cdb_grant        CDB offer / arbiter acceptance of the FIFO head
//   cdb_tag/cdb_result         head entry (zero when the FIFO is empty)
//   cdb_illegal                head entry came from an illegal control code (macro only)
//   busy                       FIFO non-empty
module alu_exec_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [3:0]       issue_ctrl,
   input  logic [XLEN-1:0]  issue_src1,
   input  logic [XLEN-1:0]  issue_src2,
   input  logic [TAG_W-1:0] issue_tag,
   output logic             cdb_valid,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [XLEN-1:0]  cdb_result,
`ifdef ALU_ILLEGAL_TRAP_EN
   output logic             cdb_illegal,
`endif
   input  logic             cdb_grant,
   output logic             busy
);

   localparam int SHW = $clog2(XLEN);

   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_PASS = 4'b1111;

   logic [XLEN-1:0]  data_q [2];
   logic [TAG_W-1:0] tag_q  [2];
   logic [1:0]       count_q, count_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;

   logic [XLEN-1:0]  alu_res;
   logic             alu_illegal;
   logic [SHW-1:0]   shamt;
   logic             accept;
   logic             pop;

   assign shamt = issue_src2[SHW-1:0];

   always_comb begin
      alu_res     = '0;
      alu_illegal = 1'b0;
      case (issue_ctrl)
         OP_ADD:  alu_res = issue_src1 + issue_src2;
         OP_SUB:  alu_res = issue_src1 - issue_src2;
         OP_XOR:  alu_res = issue_src1 ^ issue_src2;
         OP_OR:   alu_res = issue_src1 | issue_src2;
         OP_SRA:  alu_res = $unsigned($signed(issue_src1) >>> shamt);
         OP_PASS: alu_res = issue_src2;
         default: alu_illegal = 1'b1;
      endcase
   end

   // Ready depends only on the registered count so that the grant path
   // never loops back into the reservation station.
   assign issue_ready = (count_q < 2'd2);
   assign cdb_valid   = (count_q != 2'd0);
   assign busy        = cdb_valid;
   assign accept      = issue_valid && issue_ready;
   assign pop         = cdb_valid && cdb_grant;

   // Entries are zeroed on pop, so the head reads 0 whenever the FIFO is empty.
   assign cdb_tag    = tag_q[rd_ptr_q];
   assign cdb_result = data_q[rd_ptr_q];

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (flush) begin
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end else begin
         if (accept) wr_ptr_d = ~wr_ptr_q;
         if (pop)    rd_ptr_d = ~rd_ptr_q;
         if (accept && !pop)      count_d = count_q + 2'd1;
         else if (pop && !accept) count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         if (flush) begin
            for (int i = 0; i < 2; i++) begin
               data_q[i] <= '0;
               tag_q[i]  <= '0;
            end
         end else begin
            // A write and a pop never target the same slot: pop needs count>=1,
            // and with count==1 the write pointer is the other slot.
            if (pop) begin
               data_q[rd_ptr_q] <= '0;
               tag_q[rd_ptr_q]  <= '0;
            end
            if (accept) begin
               data_q[wr_ptr_q] <= alu_res;
               tag_q[wr_ptr_q]  <= issue_tag;
            end
         end
      end
   end

`ifdef ALU_ILLEGAL_TRAP_EN
   logic ill_q [2];

   assign cdb_illegal = ill_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ill_q[0] <= 1'b0;
         ill_q[1] <= 1'b0;
      end else if (flush) begin
         ill_q[0] <= 1'b0;
         ill_q[1] <= 1'b0;
      end else begin
         if (pop)    ill_q[rd_ptr_q] <= 1'b0;
         if (accept) ill_q[wr_ptr_q] <= alu_illegal;
      end
   end
`else
   logic unused_illegal;
   assign unused_illegal = alu_illegal;
`endif

endmodule
